pipe_stall_ctrl: RTL

Parametrised pipeline stall/flush controller for the RV32I core. It replaces the fixed 6-bit priority stall encoder. Per-requester stall masks are parameters. The block adds:
- registered flush sequencing with a pending state when a flush collides with a hard stall;
- a global ready gate;
- a sticky stall watchdog.

It drives the stall and flush vectors consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.

---
 rtl/pipe_stall_ctrl_pkg.sv | 30 +++
 rtl/pipe_stall_ctrl_stall_prio_sel.sv | 30 +++
 rtl/pipe_stall_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stage/requester indices,
// default masks and FSM state encoding.
package pipe_stall_ctrl_pkg;

   localparam int STAGES_DEF = 6;
   localparam int NREQ_DEF   = 4;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam int REQ_JUMP = 0;
   localparam int REQ_IF   = 1;
   localparam int REQ_ID   = 2;
   localparam int REQ_MEM  = 3;

   localparam logic [NREQ_DEF*STAGES_DEF-1:0] DEF_REQ_MASK =
      {6'b011111, 6'b000111, 6'b000011, 6'b000010};
   localparam logic [NREQ_DEF-1:0]   DEF_HARD_MASK  = 4'((1 << REQ_ID) | (1 << REQ_MEM));
   localparam logic [STAGES_DEF-1:0] DEF_FLUSH_MASK = 6'((1 << STALL_IF) | (1 << STALL_ID));

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } fsm_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_stall_prio_sel.sv
// Highest-index-wins stall mask selector: returns the mask of the single winning
// requester (not an OR of all active masks), or zero when nobody requests.
module stall_prio_sel
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int STAGES = STAGES_DEF,
   parameter logic [NREQ*STAGES-1:0] REQ_MASK = '0
) (
   input  logic [NREQ-1:0]   req,
   output logic [STAGES-1:0] sel
);

   logic [STAGES-1:0] mask_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign mask_arr[gi] = REQ_MASK[gi*STAGES +: STAGES];
      end
   endgenerate

   // Ascending scan so the last (highest-index) active requester overwrites the rest.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) sel = mask_arr[i];
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: priority stall select, pending-flush FSM, ready gate,
// sticky watchdog. Optional perf counters under macro PIPE_CTRL_PERF_EN.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int STAGES = STAGES_DEF,
   parameter int NREQ   = NREQ_DEF,
   parameter logic [NREQ*STAGES-1:0] REQ_MASK   = DEF_REQ_MASK,
   parameter logic [NREQ-1:0]        HARD_MASK  = DEF_HARD_MASK,
   parameter logic [STAGES-1:0]      FLUSH_MASK = DEF_FLUSH_MASK,
   parameter int WD_LIMIT = 1024,
   parameter int CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [NREQ-1:0]   stall_req,
   input  logic              flush_req,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic              flush_pending,
   output logic              stall_timeout,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   fsm_state_t        state_reg, state_next;
   logic              hard_act;
   logic              flush_go;
   logic [NREQ-1:0]   eff_req;
   logic [STAGES-1:0] sel_mask;
   logic              stall_busy;

   assign hard_act = |(stall_req & HARD_MASK);
   // rst also gates flush_go so nothing issues while reset is held.
   assign flush_go = ~rst & rdy & ~hard_act & (flush_req | (state_reg == ST_PEND));
   assign eff_req  = flush_go ? (stall_req & HARD_MASK) : stall_req;

   stall_prio_sel #(
      .NREQ     (NREQ),
      .STAGES   (STAGES),
      .REQ_MASK (REQ_MASK)
   ) u_sel (
      .req (eff_req),
      .sel (sel_mask)
   );

   always_comb begin
      stall = '0;
      flush = '0;
      if (!rst) begin
         if (!rdy) begin
            stall = '1;
         end else begin
            stall = sel_mask;
            if (flush_go) flush = FLUSH_MASK;
         end
      end
   end

   assign stall_busy    = |stall;
   assign flush_pending = (state_reg == ST_PEND) & ~rst;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Repeated flush_req while pending merges into the one outstanding flush.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (flush_req && !flush_go) state_next = ST_PEND;
         ST_PEND: if (flush_go)               state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   generate
      if (WD_LIMIT == 0) begin : g_no_wd
         assign stall_timeout = 1'b0;
      end else begin : g_wd
         localparam int WD_W = $clog2(WD_LIMIT + 1);
         localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);
         logic [WD_W-1:0] wd_cnt_reg;
         logic            timeout_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               wd_cnt_reg  <= '0;
               timeout_reg <= 1'b0;
            end else if (rdy) begin
               if (stall_busy) begin
                  if (wd_cnt_reg != WD_MAX) wd_cnt_reg <= wd_cnt_reg + 1'b1;
                  if (wd_cnt_reg == WD_MAX - 1'b1) timeout_reg <= 1'b1;
               end else begin
                  wd_cnt_reg <= '0;
               end
            end
         end

         assign stall_timeout = timeout_reg;
      end
   endgenerate

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cycles_reg;
   logic [CNT_W-1:0] flush_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         if (rdy && stall_busy) stall_cycles_reg <= stall_cycles_reg + 1'b1;
         if (|flush)            flush_count_reg  <= flush_count_reg + 1'b1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
